seg7_scroll_bank: RTL

Parametrised display buffer for the board's multiplexed 7-segment digits. It replaces the fixed four-register bank with a DEPTH-entry message buffer that a window of DIGITS consecutive entries is read from. The window can be held static, stepped manually, or auto-scrolled by an internal prescaler. It sits between the processor's memory-mapped write port and the per-digit seg7 decoders.

---
 rtl/seg7_scroll_bank_if.sv | 27 ++
 rtl/seg7_scroll_bank.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg7_scroll_bank_if.sv
// Bus between the processor write port / scroll controls and the display buffer.
// The driver side (processor) takes master; the buffer takes slave.
interface seg7_scroll_bank_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 9,
  parameter int AW     = 4
);
  logic                    Write;
  logic [AW-1:0]           addr;
  logic [WIDTH-1:0]        valuein;
  logic [AW:0]             length;
  logic                    run;
  logic                    step;
  logic [DIGITS*WIDTH-1:0] seg_out;
  logic [AW-1:0]           pos;
  logic                    wrap;

  modport master (
    output Write, addr, valuein, length, run, step,
    input  seg_out, pos, wrap
  );

  modport slave (
    input  Write, addr, valuein, length, run, step,
    output seg_out, pos, wrap
  );
endinterface

// File: rtl/seg7_scroll_bank.sv
// Scrolling message buffer feeding DIGITS seven-segment decoders.
// Build option SEG7_BLANK_GAP_EN: pad the message with DIGITS blank (all-ones) slots.
//
// state | meaning
// STOP  | window frozen; a step rising edge advances it once
// RUN   | prescaler running; window advances every PRESCALE cycles
module seg7_scroll_bank #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 9,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int PRESCALE = 25000000
) (
  input  logic clock,
  input  logic Resetn,
  seg7_scroll_bank_if.slave bus
);

  // Positions need one extra bit so that L + DIGITS fits with the blank gap on.
  localparam int PW = AW + 2;
  localparam int CW = $clog2(PRESCALE);
`ifdef SEG7_BLANK_GAP_EN
  localparam logic [WIDTH-1:0] FILL = '1;
`else
  localparam logic [WIDTH-1:0] FILL = '0;
`endif

  typedef enum logic {STOP, RUN} state_t;

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PW-1:0]           pos_r, pos_nxt;
  logic [PW-1:0]           len_ext, len_eff, period;
  logic [CW-1:0]           presc, presc_nxt;
  logic                    step_s, step_prev;
  logic                    tick, advance, shrink, at_last, wrap_nxt;
  logic [PW-1:0]           cur;
  logic [DIGITS*WIDTH-1:0] win, seg_r;
  logic                    wrap_r;

  always_comb begin
    len_ext = {1'b0, bus.length};
    len_eff = (len_ext > PW'(DEPTH)) ? PW'(DEPTH) : len_ext;
`ifdef SEG7_BLANK_GAP_EN
    period = len_eff + PW'(DIGITS);
`else
    period = len_eff;
`endif
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) state <= STOP;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick      = 1'b0;
    presc_nxt = '0;
    case (state)
      STOP: if (bus.run) state_nxt = RUN;
      RUN: begin
        if (!bus.run) begin
          state_nxt = STOP;
        end else if (presc == CW'(PRESCALE - 1)) begin
          tick = 1'b1;
        end else begin
          presc_nxt = presc + CW'(1);
        end
      end
      default: state_nxt = STOP;
    endcase
    advance = tick | ((state == STOP) & ~bus.run & step_s & ~step_prev);
  end

  // A shrunken length that strands pos outside the period snaps back silently.
  always_comb begin
    shrink   = (pos_r >= period);
    at_last  = (pos_r == period - PW'(1));
    pos_nxt  = pos_r;
    wrap_nxt = 1'b0;
    if (shrink) begin
      pos_nxt = '0;
    end else if (advance && period > PW'(1)) begin
      if (at_last) begin
        pos_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        pos_nxt = pos_r + PW'(1);
      end
    end
  end

  always_comb begin
    win = {DIGITS{FILL}};
    cur = '0;
    if (period != '0) begin
      cur = shrink ? (pos_r % period) : pos_r;
      for (int k = 0; k < DIGITS; k++) begin
        if (cur < len_eff) win[k*WIDTH +: WIDTH] = mem[cur[AW-1:0]];
        else               win[k*WIDTH +: WIDTH] = FILL;
        cur = (cur + PW'(1) == period) ? '0 : cur + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pos_r     <= '0;
      presc     <= '0;
      step_s    <= 1'b0;
      step_prev <= 1'b0;
      seg_r     <= '0;
      wrap_r    <= 1'b0;
    end else begin
      if (bus.Write) mem[bus.addr] <= bus.valuein;
      pos_r     <= pos_nxt;
      presc     <= presc_nxt;
      step_s    <= bus.step;
      step_prev <= step_s;
      seg_r     <= win;
      wrap_r    <= wrap_nxt;
    end
  end

  assign bus.seg_out = seg_r;
  assign bus.pos     = pos_r[AW-1:0];
  assign bus.wrap    = wrap_r;

endmodule
